// File: rtl/periph_bus.sv
// periph_bus: CPU data-port address decoder and router to memory-mapped peripheral slots.
// Forwards registered rd/wr strobes to the addressed slot and returns its read data,
// or ERR_WORD with an err pulse on unmapped access, timeout or request-while-busy.
module periph_bus #(
  parameter int unsigned NPERIPH  = 4,
  parameter logic [7:0]  BASE     = 8'hF0,
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [31:0]           addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  err,
  output logic [NPERIPH-1:0]    p_rd_en,
  output logic [NPERIPH-1:0]    p_wr_en,
  output logic [15:0]           p_addr,
  output logic [31:0]           p_wr_data,
  input  logic [NPERIPH*32-1:0] p_rd_data,
  input  logic [NPERIPH-1:0]    p_rd_valid
);

  localparam int unsigned SW = $clog2(NPERIPH);
  localparam int unsigned CW = 8;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [SW-1:0]       r_slot, w_slot_nxt;
  logic [31:0]         r_rd_data, w_rd_data_nxt;
  logic                r_rd_valid, w_rd_valid_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_err, w_err_nxt;
  logic [NPERIPH-1:0]  r_p_rd_en, w_p_rd_en_nxt;
  logic [NPERIPH-1:0]  r_p_wr_en, w_p_wr_en_nxt;
  logic [15:0]         r_p_addr, w_p_addr_nxt;
  logic [31:0]         r_p_wr_data, w_p_wr_data_nxt;

  logic [SW-1:0]       w_slot_in;
  logic [NPERIPH-1:0]  w_onehot;
  logic                w_mapped;
  logic                w_req;
  logic                w_sel_valid;
  logic [31:0]         w_sel_data;
  logic                w_unused;

  // Request decode; NPERIPH is a power of two so every slot index is in range
  assign w_slot_in   = addr[16+SW-1:16];
  assign w_onehot    = NPERIPH'(1) << w_slot_in;
  assign w_mapped    = (addr[31:24] == BASE);
  assign w_req       = rd_en | wr_en;
  assign w_sel_valid = p_rd_valid[r_slot];
  assign w_unused    = ^addr[23:16+SW];

  // Mux the latched slot's read data
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NPERIPH; i++) begin
      if (r_slot == SW'(i)) w_sel_data = p_rd_data[32*i +: 32];
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_slot      <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_p_rd_en   <= '0;
      r_p_wr_en   <= '0;
      r_p_addr    <= '0;
      r_p_wr_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_slot      <= w_slot_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_err       <= w_err_nxt;
      r_p_rd_en   <= w_p_rd_en_nxt;
      r_p_wr_en   <= w_p_wr_en_nxt;
      r_p_addr    <= w_p_addr_nxt;
      r_p_wr_data <= w_p_wr_data_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_slot_nxt      = r_slot;
    w_rd_data_nxt   = r_rd_data;
    w_rd_valid_nxt  = 1'b0;
    w_busy_nxt      = r_busy;
    w_err_nxt       = 1'b0;
    w_p_rd_en_nxt   = '0;
    w_p_wr_en_nxt   = '0;
    w_p_addr_nxt    = r_p_addr;
    w_p_wr_data_nxt = r_p_wr_data;

    case (r_state)
      ST_IDLE: begin
        if (w_mapped) begin
          if (w_req) w_p_addr_nxt = addr[15:0];
          if (wr_en) begin
            w_p_wr_en_nxt   = w_onehot;
            w_p_wr_data_nxt = wr_data;
          end
          if (rd_en) begin
            w_p_rd_en_nxt = w_onehot;
            w_busy_nxt    = 1'b1;
            w_slot_nxt    = w_slot_in;
            w_cnt_nxt     = '0;
            w_state_nxt   = ST_WAIT;
          end
        end else begin
          if (rd_en) begin
            w_rd_valid_nxt = 1'b1;
            w_rd_data_nxt  = ERR_WORD;
          end
          if (w_req) w_err_nxt = 1'b1;
        end
      end

      ST_WAIT: begin
        // Any new request while a read is outstanding is rejected
        if (w_req) w_err_nxt = 1'b1;
        if (w_sel_valid) begin
          w_rd_valid_nxt = 1'b1;
          w_rd_data_nxt  = w_sel_data;
          w_busy_nxt     = 1'b0;
          w_state_nxt    = ST_IDLE;
        end else if (r_cnt == CW'(TIMEOUT)) begin
          w_rd_valid_nxt = 1'b1;
          w_rd_data_nxt  = ERR_WORD;
          w_err_nxt      = 1'b1;
          w_busy_nxt     = 1'b0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign busy      = r_busy;
  assign err       = r_err;
  assign p_rd_en   = r_p_rd_en;
  assign p_wr_en   = r_p_wr_en;
  assign p_addr    = r_p_addr;
  assign p_wr_data = r_p_wr_data;

endmodule

// File: tb/tb_periph_bus.sv
// tb_periph_bus: directed self-checking bench for periph_bus (NPERIPH=4, TIMEOUT=15).
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_periph_bus;

  localparam int unsigned NP = 4;

  logic          clk;
  logic          rst_n;
  logic          rd_en;
  logic          wr_en;
  logic [31:0]   addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          busy;
  logic          err;
  logic [NP-1:0] p_rd_en;
  logic [NP-1:0] p_wr_en;
  logic [15:0]   p_addr;
  logic [31:0]   p_wr_data;
  logic [NP*32-1:0] p_rd_data;
  logic [NP-1:0] p_rd_valid;

  int n_checks = 0;
  int n_fail   = 0;

  periph_bus #(
    .NPERIPH (NP),
    .BASE    (8'hF0),
    .TIMEOUT (15),
    .ERR_WORD(32'hDEADBEEF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .err       (err),
    .p_rd_en   (p_rd_en),
    .p_wr_en   (p_wr_en),
    .p_addr    (p_addr),
    .p_wr_data (p_wr_data),
    .p_rd_data (p_rd_data),
    .p_rd_valid(p_rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    p_rd_valid = '0;
  endtask

  // Outputs while held in reset and right after release
  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); addr = '0; wr_data = '0; p_rd_data = '0;
    #3;
    n_checks++;
    if ({rd_data, rd_valid, busy, err, p_rd_en, p_wr_en, p_addr, p_wr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs rd_data=%h rv=%b busy=%b err=%b prd=%b pwr=%b paddr=%h pwd=%h want all 0",
               rd_data, rd_valid, busy, err, p_rd_en, p_wr_en, p_addr, p_wr_data);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({rd_valid, busy, err, p_rd_en, p_wr_en} !== '0) begin
      n_fail++;
      $display("FAIL reset_release rv=%b busy=%b err=%b prd=%b pwr=%b want 0", rd_valid, busy, err, p_rd_en, p_wr_en);
    end
  endtask

  // Write LED (slot 0) then read it back with a one-cycle responder
  task automatic test_led();
    addr = 32'hF000_0000; wr_data = 32'h0000_0001; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if ({p_wr_en, p_rd_en, p_addr, p_wr_data, err, rd_valid} !== {4'b0001, 4'b0000, 16'h0000, 32'h1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL led_write pwr=%b prd=%b paddr=%h pwd=%h err=%b rv=%b want 0001 0000 0000 00000001 0 0",
               p_wr_en, p_rd_en, p_addr, p_wr_data, err, rd_valid);
    end
    tick();
    n_checks++;
    if ({p_wr_en, err, busy} !== {4'b0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL led_write_pulse pwr=%b err=%b busy=%b want 0000 0 0", p_wr_en, err, busy);
    end
    rd_en = 1'b1;                                   // cycle 0
    tick();                                         // cycle 1
    rd_en = 1'b0;
    n_checks++;
    if ({p_rd_en, busy, rd_valid, err} !== {4'b0001, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL led_rd_strobe prd=%b busy=%b rv=%b err=%b want 0001 1 0 0", p_rd_en, busy, rd_valid, err);
    end
    tick();                                         // cycle 2: LED answers
    p_rd_valid = 4'b0001; p_rd_data[31:0] = 32'h0000_0001;
    n_checks++;
    if ({p_rd_en, rd_valid, busy} !== {4'b0000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL led_cycle2 prd=%b rv=%b busy=%b want 0000 0 1", p_rd_en, rd_valid, busy);
    end
    tick();                                         // cycle 3
    p_rd_valid = '0;
    n_checks++;
    if ({rd_valid, rd_data, busy, err} !== {1'b1, 32'h0000_0001, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL led_read rv=%b data=%h busy=%b err=%b want 1 00000001 0 0", rd_valid, rd_data, busy, err);
    end
    tick();
    n_checks++;
    if ({rd_valid, rd_data} !== {1'b0, 32'h0000_0001}) begin
      n_fail++;
      $display("FAIL led_hold rv=%b data=%h want 0 00000001", rd_valid, rd_data);
    end
  endtask

  // Slot 3 answers 5 cycles after its strobe
  task automatic test_slot3_delay();
    addr = 32'hF003_0004; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if ({p_rd_en, p_addr, busy} !== {4'b1000, 16'h0004, 1'b1}) begin
      n_fail++;
      $display("FAIL s3_strobe prd=%b paddr=%h busy=%b want 1000 0004 1", p_rd_en, p_addr, busy);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({busy, rd_valid, err, p_rd_en} !== {1'b1, 1'b0, 1'b0, 4'b0000}) begin
        n_fail++;
        $display("FAIL s3_wait%0d busy=%b rv=%b err=%b prd=%b want 1 0 0 0000", i, busy, rd_valid, err, p_rd_en);
      end
    end
    p_rd_valid = 4'b1000; p_rd_data[127:96] = 32'h1234_5678;
    tick();
    p_rd_valid = '0;
    n_checks++;
    if ({rd_valid, rd_data, busy, err} !== {1'b1, 32'h1234_5678, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL s3_resp rv=%b data=%h busy=%b err=%b want 1 12345678 0 0", rd_valid, rd_data, busy, err);
    end
  endtask

  // Slot 2 never answers: ERR_WORD with err TIMEOUT+1 cycles after the strobe
  task automatic test_timeout();
    addr = 32'hF002_0000; rd_en = 1'b1;
    tick();                                          // strobe cycle
    rd_en = 1'b0;
    n_checks++;
    if ({p_rd_en, busy} !== {4'b0100, 1'b1}) begin
      n_fail++;
      $display("FAIL to_strobe prd=%b busy=%b want 0100 1", p_rd_en, busy);
    end
    for (int i = 1; i <= 15; i++) begin
      tick();
      n_checks++;
      if ({rd_valid, err, busy} !== 3'b001) begin
        n_fail++;
        $display("FAIL to_wait+%0d rv=%b err=%b busy=%b want 0 0 1", i, rd_valid, err, busy);
      end
    end
    tick();                                          // strobe + 16
    n_checks++;
    if ({rd_valid, rd_data, err, busy} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL to_resp rv=%b data=%h err=%b busy=%b want 1 deadbeef 1 0", rd_valid, rd_data, err, busy);
    end
    addr = 32'hF001_0020; wr_data = 32'h0000_00A5; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if ({rd_valid, err, p_wr_en, p_addr, p_wr_data} !== {1'b0, 1'b0, 4'b0010, 16'h0020, 32'hA5}) begin
      n_fail++;
      $display("FAIL to_idle_write rv=%b err=%b pwr=%b paddr=%h pwd=%h want 0 0 0010 0020 000000a5",
               rd_valid, err, p_wr_en, p_addr, p_wr_data);
    end
  endtask

  // Valid arriving in the same cycle the counter hits TIMEOUT
  task automatic test_valid_at_timeout();
    addr = 32'hF001_0000; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    p_rd_valid = 4'b0010; p_rd_data[63:32] = 32'h0BAD_F00D;
    tick();
    p_rd_valid = '0;
    n_checks++;
    if ({rd_valid, rd_data, err, busy} !== {1'b1, 32'h0BAD_F00D, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL valid_at_to rv=%b data=%h err=%b busy=%b want 1 0badf00d 0 0", rd_valid, rd_data, err, busy);
    end
  endtask

  // Read and write together to one slot; slot answers in the strobe cycle
  task automatic test_rd_wr_together();
    addr = 32'hF0A1_0010; wr_data = 32'h5555_AAAA; rd_en = 1'b1; wr_en = 1'b1;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    n_checks++;
    if ({p_rd_en, p_wr_en, p_addr, p_wr_data, busy} !== {4'b0010, 4'b0010, 16'h0010, 32'h5555_AAAA, 1'b1}) begin
      n_fail++;
      $display("FAIL rw_strobes prd=%b pwr=%b paddr=%h pwd=%h busy=%b want 0010 0010 0010 5555aaaa 1",
               p_rd_en, p_wr_en, p_addr, p_wr_data, busy);
    end
    p_rd_valid = 4'b0010; p_rd_data[63:32] = 32'h0000_0777;
    tick();
    p_rd_valid = '0;
    n_checks++;
    if ({rd_valid, rd_data, err, p_wr_en} !== {1'b1, 32'h0000_0777, 1'b0, 4'b0000}) begin
      n_fail++;
      $display("FAIL rw_resp rv=%b data=%h err=%b pwr=%b want 1 00000777 0 0000", rd_valid, rd_data, err, p_wr_en);
    end
  endtask

  // Base mismatch read and write
  task automatic test_unmapped();
    addr = 32'h1000_0000; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if ({rd_valid, rd_data, err, busy, p_rd_en, p_wr_en} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'b0, 4'b0}) begin
      n_fail++;
      $display("FAIL unm_read rv=%b data=%h err=%b busy=%b prd=%b pwr=%b want 1 deadbeef 1 0 0000 0000",
               rd_valid, rd_data, err, busy, p_rd_en, p_wr_en);
    end
    wr_data = 32'h0000_0055; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if ({err, rd_valid, p_rd_en, p_wr_en, p_wr_data} !== {1'b1, 1'b0, 4'b0, 4'b0, 32'h5555_AAAA}) begin
      n_fail++;
      $display("FAIL unm_write err=%b rv=%b prd=%b pwr=%b pwd=%h want 1 0 0000 0000 5555aaaa",
               err, rd_valid, p_rd_en, p_wr_en, p_wr_data);
    end
    tick();
    n_checks++;
    if ({err, rd_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL unm_err_pulse err=%b rv=%b want 0 0", err, rd_valid);
    end
  endtask

  // Requests while busy, foreign-slot valid, and a request in the final WAIT cycle
  task automatic test_busy_request();
    addr = 32'hF003_0008; rd_en = 1'b1;
    tick();                                          // c1
    addr = 32'hF001_0000; rd_en = 1'b1;
    p_rd_valid = 4'b0001; p_rd_data[31:0] = 32'hAAAA_AAAA;
    tick();                                          // c2
    rd_en = 1'b0; p_rd_valid = '0;
    n_checks++;
    if ({err, rd_valid, busy, p_rd_en} !== {1'b1, 1'b0, 1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL busy_req err=%b rv=%b busy=%b prd=%b want 1 0 1 0000", err, rd_valid, busy, p_rd_en);
    end
    tick();                                          // c3
    n_checks++;
    if ({err, rd_valid, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL busy_quiet err=%b rv=%b busy=%b want 0 0 1", err, rd_valid, busy);
    end
    p_rd_valid = 4'b1000; p_rd_data[127:96] = 32'hCAFE_F00D;
    addr = 32'hF000_0000; wr_data = 32'h0000_00FF; wr_en = 1'b1;
    tick();                                          // c4
    p_rd_valid = '0; wr_en = 1'b0;
    n_checks++;
    if ({rd_valid, rd_data, err, busy, p_wr_en} !== {1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 4'b0000}) begin
      n_fail++;
      $display("FAIL busy_final rv=%b data=%h err=%b busy=%b pwr=%b want 1 cafef00d 1 0 0000",
               rd_valid, rd_data, err, busy, p_wr_en);
    end
    tick();
    n_checks++;
    if ({err, rd_valid, p_wr_en} !== {1'b0, 1'b0, 4'b0000}) begin
      n_fail++;
      $display("FAIL busy_after err=%b rv=%b pwr=%b want 0 0 0000", err, rd_valid, p_wr_en);
    end
  endtask

  // Reset mid-WAIT aborts the read; a late valid is ignored
  task automatic test_reset_mid_wait();
    addr = 32'hF002_0000; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rd_data, rd_valid, busy, err, p_rd_en, p_wr_en, p_addr, p_wr_data} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid rd_data=%h rv=%b busy=%b err=%b prd=%b pwr=%b paddr=%h pwd=%h want all 0",
               rd_data, rd_valid, busy, err, p_rd_en, p_wr_en, p_addr, p_wr_data);
    end
    tick();
    rst_n = 1'b1;
    p_rd_valid = 4'b0100; p_rd_data[95:64] = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({rd_valid, busy, err, rd_data} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
        n_fail++;
        $display("FAIL rst_late%0d rv=%b busy=%b err=%b data=%h want 0 0 0 00000000", i, rd_valid, busy, err, rd_data);
      end
    end
    p_rd_valid = '0;
  endtask

  initial begin
    test_reset();
    test_led();
    test_slot3_delay();
    test_timeout();
    test_valid_at_timeout();
    test_rd_wr_together();
    test_unmapped();
    test_busy_request();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
